// File: rtl/dmc_pkg.sv
// Shared constants and types for the two-bank data memory arbiter.
package dmc_pkg;

  localparam int unsigned DMC_DW        = 8;
  localparam int unsigned DMC_AW        = 8;
  localparam int unsigned DMC_NUM_BANKS = 2;
  localparam int unsigned DMC_NUM_PORTS = 2;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  // One stage of the read-return tag pipeline: a read is in flight and which port owns it.
  typedef struct packed {
    logic vld;
    logic own;
  } dmc_tag_t;

  // True when a requester is asking for the given bank.
  function automatic logic dmc_targets(input logic req, input logic bank, input logic target);
    return req && (bank == target);
  endfunction

endpackage

// File: rtl/dmc_rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit pointer.
// The pointer only moves after a contended grant; lone requests leave it alone.
module dmc_rr_arb2
  import dmc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0 favours P0, 1 favours P1.
  logic ptr_q, ptr_d;

  // Grant decode and pointer update; nothing is granted while in reset.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (!rst_i) begin
      unique case (req_i)
        2'b01: gnt_o[P0] = 1'b1;
        2'b10: gnt_o[P1] = 1'b1;
        2'b11: begin
          if (ptr_q) begin
            gnt_o[P1] = 1'b1;
          end else begin
            gnt_o[P0] = 1'b1;
          end
          ptr_d = ~ptr_q;
        end
        default: gnt_o = '0;
      endcase
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmc_bank_arbiter.sv
// Two-port / two-bank data memory arbiter. Per-bank round-robin on conflicts,
// registered bank command buses and a two-stage tag pipeline that steers read
// data back to the issuing port two clocks after acceptance.
module dmc_bank_arbiter
  import dmc_pkg::*;
#(
  parameter int unsigned DW = DMC_DW,
  parameter int unsigned AW = DMC_AW
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_req,
  input  logic          p0_bank,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,

  input  logic          p1_req,
  input  logic          p1_bank,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,

  output logic          bank_a_en,
  output logic          bank_a_we,
  output logic [AW-1:0] bank_a_addr,
  output logic [DW-1:0] bank_a_wdata,
  input  logic [DW-1:0] bank_a_rdata,

  output logic          bank_b_en,
  output logic          bank_b_we,
  output logic [AW-1:0] bank_b_addr,
  output logic [DW-1:0] bank_b_wdata,
  input  logic [DW-1:0] bank_b_rdata
);

  // Port-indexed views of the requester buses.
  logic [DMC_NUM_PORTS-1:0]         port_we;
  logic [DMC_NUM_PORTS-1:0][AW-1:0] port_addr;
  logic [DMC_NUM_PORTS-1:0][DW-1:0] port_wdata;

  assign port_we    = {p1_we, p0_we};
  assign port_addr  = {p1_addr, p0_addr};
  assign port_wdata = {p1_wdata, p0_wdata};

  // Per-bank request vectors, bit index = port.
  logic [1:0] req_a, req_b, gnt_a, gnt_b;

  assign req_a = {dmc_targets(p1_req, p1_bank, BANK_A), dmc_targets(p0_req, p0_bank, BANK_A)};
  assign req_b = {dmc_targets(p1_req, p1_bank, BANK_B), dmc_targets(p0_req, p0_bank, BANK_B)};

  dmc_rr_arb2 u_arb_a (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req_a),
    .gnt_o (gnt_a)
  );

  dmc_rr_arb2 u_arb_b (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req_b),
    .gnt_o (gnt_b)
  );

  // A port only ever targets one bank, so at most one of these bits is set.
  assign p0_gnt = gnt_a[P0] | gnt_b[P0];
  assign p1_gnt = gnt_a[P1] | gnt_b[P1];

  // Bank-indexed grant vectors, [bank][port].
  logic [DMC_NUM_BANKS-1:0][1:0]    bank_gnt;
  logic [DMC_NUM_BANKS-1:0][DW-1:0] bank_rdata;

  assign bank_gnt   = {gnt_b, gnt_a};
  assign bank_rdata = {bank_b_rdata, bank_a_rdata};

  // Command registers and tag pipeline state.
  logic     [DMC_NUM_BANKS-1:0]         cmd_en_d, cmd_en_q;
  logic     [DMC_NUM_BANKS-1:0]         cmd_we_d, cmd_we_q;
  logic     [DMC_NUM_BANKS-1:0][AW-1:0] cmd_addr_d, cmd_addr_q;
  logic     [DMC_NUM_BANKS-1:0][DW-1:0] cmd_wdata_d, cmd_wdata_q;
  dmc_tag_t [DMC_NUM_BANKS-1:0]         tag1_d, tag1_q, tag2_d, tag2_q;

  // Read return registers.
  logic [DMC_NUM_PORTS-1:0]         rvalid_d, rvalid_q;
  logic [DMC_NUM_PORTS-1:0][DW-1:0] rdata_d, rdata_q;

  // Load the winning request onto each bank's command bus; idle banks keep addr/wdata.
  always_comb begin
    logic sel;
    cmd_en_d    = '0;
    cmd_we_d    = '0;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    tag1_d      = '0;
    sel         = 1'b0;
    for (int b = 0; b < int'(DMC_NUM_BANKS); b++) begin
      sel = bank_gnt[b][P1];
      if (|bank_gnt[b]) begin
        cmd_en_d[b]    = 1'b1;
        cmd_we_d[b]    = port_we[sel];
        cmd_addr_d[b]  = port_addr[sel];
        cmd_wdata_d[b] = port_wdata[sel];
        tag1_d[b].vld  = ~port_we[sel];
        tag1_d[b].own  = sel;
      end
    end
  end

  // Second tag stage lines up with the cycle the bank presents its read data.
  always_comb begin
    tag2_d = tag1_q;
  end

  // Steer completing read data to its owner; rdata holds between returns.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int b = 0; b < int'(DMC_NUM_BANKS); b++) begin
      if (tag2_q[b].vld) begin
        rvalid_d[tag2_q[b].own] = 1'b1;
        rdata_d[tag2_q[b].own]  = bank_rdata[b];
      end
    end
  end

  // State registers; reset drops any in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_en_q    <= '0;
      cmd_we_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_en_q    <= cmd_en_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bank_a_en    = cmd_en_q[BANK_A];
  assign bank_a_we    = cmd_we_q[BANK_A];
  assign bank_a_addr  = cmd_addr_q[BANK_A];
  assign bank_a_wdata = cmd_wdata_q[BANK_A];

  assign bank_b_en    = cmd_en_q[BANK_B];
  assign bank_b_we    = cmd_we_q[BANK_B];
  assign bank_b_addr  = cmd_addr_q[BANK_B];
  assign bank_b_wdata = cmd_wdata_q[BANK_B];

  assign p0_rvalid = rvalid_q[P0];
  assign p0_rdata  = rdata_q[P0];
  assign p1_rvalid = rvalid_q[P1];
  assign p1_rdata  = rdata_q[P1];

  // Structural invariants of the grant logic.
  gnt_needs_req_a : assert property (@(posedge clk) (gnt_a & ~req_a) == 2'b00);
  gnt_needs_req_b : assert property (@(posedge clk) (gnt_b & ~req_b) == 2'b00);
  gnt_onehot_a    : assert property (@(posedge clk) gnt_a != 2'b11);
  gnt_onehot_b    : assert property (@(posedge clk) gnt_b != 2'b11);

endmodule

// File: tb/tb_dmc_bank_arbiter.sv
// Directed bench for dmc_bank_arbiter with a scoreboard on the read-return path.
module tb_dmc_bank_arbiter;
  import dmc_pkg::*;

  logic       clk, rst;
  logic       p0_req, p0_bank, p0_we, p0_gnt, p0_rvalid;
  logic [7:0] p0_addr, p0_wdata, p0_rdata;
  logic       p1_req, p1_bank, p1_we, p1_gnt, p1_rvalid;
  logic [7:0] p1_addr, p1_wdata, p1_rdata;
  logic       bank_a_en, bank_a_we, bank_b_en, bank_b_we;
  logic [7:0] bank_a_addr, bank_a_wdata, bank_a_rdata;
  logic [7:0] bank_b_addr, bank_b_wdata, bank_b_rdata;

  dmc_bank_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (p0_req),
    .p0_bank      (p0_bank),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_gnt       (p0_gnt),
    .p0_rvalid    (p0_rvalid),
    .p0_rdata     (p0_rdata),
    .p1_req       (p1_req),
    .p1_bank      (p1_bank),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_gnt       (p1_gnt),
    .p1_rvalid    (p1_rvalid),
    .p1_rdata     (p1_rdata),
    .bank_a_en    (bank_a_en),
    .bank_a_we    (bank_a_we),
    .bank_a_addr  (bank_a_addr),
    .bank_a_wdata (bank_a_wdata),
    .bank_a_rdata (bank_a_rdata),
    .bank_b_en    (bank_b_en),
    .bank_b_we    (bank_b_we),
    .bank_b_addr  (bank_b_addr),
    .bank_b_wdata (bank_b_wdata),
    .bank_b_rdata (bank_b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank memories: registered read, write visible to any later cycle.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  always @(posedge clk) begin
    if (bank_a_en) begin
      if (bank_a_we) mem_a[bank_a_addr] <= bank_a_wdata;
      else           bank_a_rdata <= mem_a[bank_a_addr];
    end
    if (bank_b_en) begin
      if (bank_b_we) mem_b[bank_b_addr] <= bank_b_wdata;
      else           bank_b_rdata <= mem_b[bank_b_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the negedge before the accepting edge: data due 3 counter ticks later.
  task automatic push(input int p, input logic [7:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 3;
    if (p == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic drive(input int p, input logic req, input logic bank, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_bank = bank; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_bank = bank; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the head of that port's scoreboard, data and timing.
  always @(negedge clk) begin
    if (p0_rvalid) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL p0_rvalid_unexpected: got rvalid with rdata %0h, expected none", p0_rdata);
      end else begin
        e0 = sb0.pop_front();
        chk("p0_rdata", p0_rdata, e0.data);
        chk("p0_rvalid_cycle", cyc, e0.cyc);
      end
    end
    if (p1_rvalid) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL p1_rvalid_unexpected: got rvalid with rdata %0h, expected none", p1_rdata);
      end else begin
        e1 = sb1.pop_front();
        chk("p1_rdata", p1_rdata, e1.data);
        chk("p1_rvalid_cycle", cyc, e1.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_a[8'h01] = 8'h11;
    mem_b[8'h02] = 8'h22;
    mem_b[8'h20] = 8'h33;
    mem_b[8'h21] = 8'h44;
    bank_a_rdata = 8'h00;
    bank_b_rdata = 8'h00;

    // Reset with a request held: no grant, everything zero.
    rst = 1'b1;
    idle();
    drive(0, 1'b1, BANK_A, 1'b1, 8'hFF, 8'hFF);
    tick(); tick();
    @(negedge clk);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_a_en", bank_a_en, 0);
    chk("rst_b_en", bank_b_en, 0);
    chk("rst_a_we", bank_a_we, 0);
    chk("rst_a_addr", bank_a_addr, 0);
    chk("rst_a_wdata", bank_a_wdata, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    tick();
    rst = 1'b0;
    idle();

    // Single port write then read of bank A.
    drive(0, 1'b1, BANK_A, 1'b1, 8'h10, 8'h5A);
    @(negedge clk);
    chk("t1_wr_gnt", p0_gnt, 1);
    chk("t1_a_idle", bank_a_en, 0);
    tick();
    drive(0, 1'b1, BANK_A, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t1_rd_gnt", p0_gnt, 1);
    chk("t1_wr_cmd_en", bank_a_en, 1);
    chk("t1_wr_cmd_we", bank_a_we, 1);
    chk("t1_wr_cmd_addr", bank_a_addr, 8'h10);
    chk("t1_wr_cmd_wdata", bank_a_wdata, 8'h5A);
    push(0, 8'h5A);
    tick();
    idle();
    @(negedge clk);
    chk("t1_rd_cmd_en", bank_a_en, 1);
    chk("t1_rd_cmd_we", bank_a_we, 0);
    chk("t1_rd_cmd_addr", bank_a_addr, 8'h10);
    tick();
    @(negedge clk);
    chk("t1_en_pulse", bank_a_en, 0);
    chk("t1_idle_addr_held", bank_a_addr, 8'h10);
    repeat (3) tick();

    // Parallel reads to different banks.
    drive(0, 1'b1, BANK_A, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, BANK_B, 1'b0, 8'h02, 8'h00);
    @(negedge clk);
    chk("t2_p0_gnt", p0_gnt, 1);
    chk("t2_p1_gnt", p1_gnt, 1);
    push(0, 8'h11);
    push(1, 8'h22);
    tick();
    idle();
    repeat (4) tick();

    // Continuous conflict on bank B alternates starting with P0.
    drive(0, 1'b1, BANK_B, 1'b0, 8'h20, 8'h00);
    drive(1, 1'b1, BANK_B, 1'b0, 8'h21, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_p0_gnt", p0_gnt, (i % 2 == 0));
      chk("t3_p1_gnt", p1_gnt, (i % 2 == 1));
      if (i > 0) chk("t3_b_en", bank_b_en, 1);
      if (i % 2 == 0) push(0, 8'h33);
      else            push(1, 8'h44);
      tick();
    end
    idle();
    @(negedge clk);
    chk("t3_b_en_last", bank_b_en, 1);
    tick();
    @(negedge clk);
    chk("t3_b_en_off", bank_b_en, 0);
    repeat (3) tick();

    // Uncontended P1 grants on A must not move the pointer.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, BANK_A, 1'b1, 8'h30 + 8'(i), 8'hA0 + 8'(i));
      @(negedge clk);
      chk("t4_p1_solo_gnt", p1_gnt, 1);
      tick();
    end
    drive(0, 1'b1, BANK_A, 1'b0, 8'h30, 8'h00);
    drive(1, 1'b1, BANK_A, 1'b0, 8'h31, 8'h00);
    @(negedge clk);
    chk("t4_p0_first", p0_gnt, 1);
    chk("t4_p1_waits", p1_gnt, 0);
    push(0, 8'hA0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_p1_next", p1_gnt, 1);
    push(1, 8'hA1);
    tick();
    idle();
    repeat (5) tick();

    // Reset while a read is in flight: it must never return.
    drive(0, 1'b1, BANK_A, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t5_rd_gnt", p0_gnt, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_gnt_in_rst", p0_gnt, 0);
    tick();
    @(negedge clk);
    chk("t5_a_en", bank_a_en, 0);
    chk("t5_a_addr", bank_a_addr, 0);
    chk("t5_p0_rdata", p0_rdata, 0);
    chk("t5_p1_rdata", p1_rdata, 0);
    tick();
    @(negedge clk);
    chk("t5_p0_rvalid", p0_rvalid, 0);
    chk("t5_a_en_rst", bank_a_en, 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Post-reset conflict on A: P0 wins, held P1 follows with its own values.
    drive(0, 1'b1, BANK_A, 1'b1, 8'h50, 8'h66);
    drive(1, 1'b1, BANK_A, 1'b1, 8'h51, 8'h99);
    @(negedge clk);
    chk("t6_p0_gnt", p0_gnt, 1);
    chk("t6_p1_held", p1_gnt, 0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_p1_gnt", p1_gnt, 1);
    chk("t6_p0_cmd_addr", bank_a_addr, 8'h50);
    chk("t6_p0_cmd_wdata", bank_a_wdata, 8'h66);
    tick();
    // Read straight after P1's write to the same bank.
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(0, 1'b1, BANK_A, 1'b0, 8'h51, 8'h00);
    @(negedge clk);
    chk("t6_rd_gnt", p0_gnt, 1);
    chk("t6_p1_cmd_en", bank_a_en, 1);
    chk("t6_p1_cmd_we", bank_a_we, 1);
    chk("t6_p1_cmd_addr", bank_a_addr, 8'h51);
    chk("t6_p1_cmd_wdata", bank_a_wdata, 8'h99);
    push(0, 8'h99);
    tick();
    idle();
    @(negedge clk);
    chk("t6_rd_cmd_we", bank_a_we, 0);
    chk("t6_rd_cmd_addr", bank_a_addr, 8'h51);
    tick();
    @(negedge clk);
    chk("t6_a_idle", bank_a_en, 0);
    repeat (5) tick();

    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmc_bank_arbiter.md
Name: dmc_bank_arbiter

Overview:
Shares the two-bank data memory (bank A, bank B) between two requesters (port 0, port 1) through a valid/grant handshake. Requests to different banks proceed in parallel; same-bank conflicts are resolved by per-bank round-robin. Drives registered command buses to both banks and returns read data to the issuing port with fixed latency. Sits between the execute-side requesters and the bank memories; replaces direct requester-to-memory wiring.

Parameters:
DW, 8, data width
AW, 8, address width per bank

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request valid
p0_bank  in  1  port 0 bank select (0=A, 1=B)
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 accepted this cycle (combinational)
p0_rvalid  out  1  port 0 read data valid
p0_rdata  out  DW  port 0 read data
p1_*  same set as p0_* for port 1
bank_a_en  out  1  bank A command valid
bank_a_we  out  1  bank A write enable
bank_a_addr  out  AW  bank A address
bank_a_wdata  out  DW  bank A write data
bank_a_rdata  in  DW  bank A read data, valid one cycle after a read command
bank_b_*  same set as bank_a_* for bank B

Behaviour:
- Reset: all bank_*_en/we, pN_rvalid = 0; bank_*_addr/wdata and pN_rdata = 0; both round-robin pointers favour port 0; in-flight read tracking cleared.
- Handshake: a request is accepted on a rising edge where pN_req && pN_gnt. Requester must hold req/bank/we/addr/wdata stable until granted. gnt never asserts without req.
- Grant: requests to different banks are both granted in the same cycle. Same-bank conflict: grant goes to the port favoured by that bank's pointer. After a contended grant, that bank's pointer moves to the other port. Uncontended grants leave the pointer unchanged.
- Command: on the accepting edge, the granted request is registered onto bank_X_* and bank_X_en=1 for exactly one cycle. An idle bank has en=0 and we=0; addr/wdata hold their last values.
- Read return: the arbiter records owner port per bank in a 2-stage tag pipeline. bank_X_rdata is registered into pN_rdata, and pN_rvalid=1 for one cycle, 2 clocks after the accepting edge. Write acceptance produces no rvalid.
- Back-to-back: one accept per port per cycle; full throughput with no bubbles.
- Read-data collision: a port can receive rdata from only one bank per cycle. It cannot have two reads complete in the same cycle, because each port issues at most one request per cycle.
- Same-bank write then read (consecutive accepts): the read returns the written data, given the memory's write-first ordering across cycles.
- Reset mid-operation: outstanding reads are dropped. rvalid stays 0 from the cycle after the reset edge. No bank command is issued while rst=1. gnt=0 while rst=1.

Decomposition:
- Shared package dmc_pkg: BANK_A=1'b0, BANK_B=1'b1; DW/AW defaults; port-index constants P0=0, P1=1.
- Sub-module dmc_rr_arb2 (2-requester round-robin with pointer register, instantiated once per bank).
- Tag pipeline and command registers stay in the top.

Test Plan:
- Single port read: after reset, p0 writes bank A addr 0x10 data 0x5A, then reads 0x10. Required: p0_gnt=1 on both; bank_a_en pulses once per accept; p0_rvalid=1 with p0_rdata=0x5A 2 clocks after the read accept.
- Parallel banks: p0 reads A@0x01 and p1 reads B@0x02 in the same cycle (memories preloaded 0x11/0x22). Required: both gnt=1 same cycle; p0_rdata=0x11, p1_rdata=0x22, both rvalid in the same cycle.
- Conflict fairness: both ports request bank B continuously for 6 cycles. Required: grants alternate P0,P1,P0,P1,P0,P1; bank_b_en high all 6 cycles.
- Uncontended pointer: p1 alone takes 3 grants on A, then both request A. Required: p0 is granted first (pointer untouched by uncontended grants).
- Reset mid-read: p0 read accepted, rst=1 on the next edge. Required: p0_rvalid never asserts; all outputs zero; next post-reset conflict grants p0 first.
- Held request: p1 req to A held while p0 wins A. Required: p1_gnt=0 that cycle, 1 the next; p1 signals unchanged; single bank_a command carries p1 values.
